// File: rtl/aes_pkg.sv
// Shared AES helpers for the pipelined final round: state layout, S-box
// functions (computed from the GF(2^8) inverse plus affine map, so the
// synthesis tool builds the ROM) and packing between the 128-bit bus and
// the [row][col] byte array.
package aes_pkg;

   localparam int BLK_W = 128;

   // state[row][col], one byte per cell
   typedef logic [3:0][3:0][7:0] state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] acc;
      logic [7:0] base;
      logic [7:0] e;
      acc  = 8'h01;
      base = a;
      e    = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) acc = gf_mul(acc, base);
         base = gf_mul(base, base);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   // bus byte 0 sits in [127:120]; bytes run down each column first
   function automatic logic [BLK_W-1:0] pack_state(input state_t s);
      logic [BLK_W-1:0] p;
      p = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            p[BLK_W-1-8*(4*c+r) -: 8] = s[r][c];
      return p;
   endfunction

   function automatic state_t unpack_state(input logic [BLK_W-1:0] p);
      state_t s;
      s = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = p[BLK_W-1-8*(4*c+r) -: 8];
      return s;
   endfunction

endpackage

// File: rtl/aes_final_round_pipe_stage.sv
// Generic valid/ready register slice carrying a data word and a mode bit.
// The slice accepts whenever it is empty or its content leaves this cycle,
// which gives full throughput without a skid buffer.
module aes_final_round_pipe_stage #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         src_valid,
   output logic         src_ready,
   input  logic [W-1:0] src_data,
   input  logic         src_mode,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         mode
);

   assign src_ready = !valid || ready;

   // load on advance; hold (data stable) while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         mode  <= 1'b0;
      end else if (src_ready) begin
         valid <= src_valid;
         if (src_valid) begin
            data <= src_data;
            mode <= src_mode;
         end
      end
   end

endmodule

// File: rtl/aes_final_round_pipe.sv
// Pipelined AES last round: SubBytes/ShiftRows (or inverse) then AddRoundKey,
// split over PIPE_DEPTH register slices with a saturating output counter.
// Optional decrypt path enabled by defining AES_FINAL_ROUND_DEC_EN; without
// it in_mode is ignored and out_mode is always 0.
module aes_final_round_pipe
   import aes_pkg::*;
#(
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_key,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             out_mode,
   output logic [CNT_W-1:0] blk_count
);

   logic             mode_eff;
   logic [BLK_W-1:0] sub_shift;
   state_t           st_in;
   state_t           st_enc;

   assign st_in = unpack_state(in_state);

   // forward S-box with the row rotation folded into the byte selection
   always_comb begin
      st_enc = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            st_enc[r][c] = sbox(st_in[r][2'(c + r)]);
   end

`ifdef AES_FINAL_ROUND_DEC_EN
   state_t st_dec;

   assign mode_eff = in_mode;

   // inverse S-box with the inverse row rotation
   always_comb begin
      st_dec = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            st_dec[r][c] = inv_sbox(st_in[r][2'(c - r + 4)]);
   end

   assign sub_shift = mode_eff ? pack_state(st_dec) : pack_state(st_enc);
`else
   // mode is forced to encrypt; the register slices then hold a constant 0
   assign mode_eff  = in_mode & 1'b0;
   assign sub_shift = pack_state(st_enc);
`endif

   generate
      if (PIPE_DEPTH == 1) begin : g_depth1
         aes_final_round_pipe_stage #(.W(BLK_W)) u_stage1 (
            .clk       (clk),
            .rst       (rst),
            .src_valid (in_valid),
            .src_ready (in_ready),
            .src_data  (sub_shift ^ in_key),
            .src_mode  (mode_eff),
            .valid     (out_valid),
            .ready     (out_ready),
            .data      (out_data),
            .mode      (out_mode)
         );
      end else if (PIPE_DEPTH == 2) begin : g_depth2
         logic               s1_valid;
         logic               s1_ready;
         logic               s1_mode;
         logic [2*BLK_W-1:0] s1_data;

         // first slice carries the round key alongside the substituted state
         aes_final_round_pipe_stage #(.W(2*BLK_W)) u_stage1 (
            .clk       (clk),
            .rst       (rst),
            .src_valid (in_valid),
            .src_ready (in_ready),
            .src_data  ({sub_shift, in_key}),
            .src_mode  (mode_eff),
            .valid     (s1_valid),
            .ready     (s1_ready),
            .data      (s1_data),
            .mode      (s1_mode)
         );

         aes_final_round_pipe_stage #(.W(BLK_W)) u_stage2 (
            .clk       (clk),
            .rst       (rst),
            .src_valid (s1_valid),
            .src_ready (s1_ready),
            .src_data  (s1_data[2*BLK_W-1:BLK_W] ^ s1_data[BLK_W-1:0]),
            .src_mode  (s1_mode),
            .valid     (out_valid),
            .ready     (out_ready),
            .data      (out_data),
            .mode      (out_mode)
         );
      end else begin : g_bad_depth
         $fatal(1, "aes_final_round_pipe: PIPE_DEPTH must be 1 or 2");
      end
   endgenerate

   // count accepted output blocks, sticking at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count <= '0;
      end else if (out_valid && out_ready && (blk_count != {CNT_W{1'b1}})) begin
         blk_count <= blk_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_final_round_pipe.sv
// Self-checking bench for aes_final_round_pipe: directed FIPS vectors plus
// random streams scored against a byte-level reference model whose S-box
// tables are generated independently of the RTL.
module tb_aes_final_round_pipe;

`ifdef AES_FINAL_ROUND_DEC_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
   logic [127:0] in_state, in_key, out_data;
   logic [31:0]  blk_count;

   logic         s_rst, s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_mode;
   logic [127:0] s_in_state, s_in_key, s_out_data;
   logic [3:0]   s_blk_count;

   aes_final_round_pipe #(.PIPE_DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .in_key(in_key), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mode(out_mode), .blk_count(blk_count));

   aes_final_round_pipe #(.PIPE_DEPTH(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_state(s_in_state), .in_key(s_in_key), .in_mode(s_in_mode),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_mode(s_out_mode), .blk_count(s_blk_count));

   logic [7:0]   sb [256];
   logic [7:0]   isb[256];
   logic [128:0] exp_q[$];
   int           out_log[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           exp_cnt = 0;
   int           cyc     = 0;
   bit           last_in_hs;

   function automatic logic [7:0] rl(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   // S-box by walking the multiplicative group with generator 3
   task automatic build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                          input logic m);
      logic [7:0]   ib[16];
      logic [7:0]   ob[16];
      logic [127:0] res;
      for (int b = 0; b < 16; b++) ib[b] = st[127-8*b -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (m && DEC_EN) ob[4*c+r] = isb[ib[4*((c - r + 4) % 4) + r]];
            else             ob[4*c+r] = sb[ib[4*((c + r) % 4) + r]];
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = ob[b] ^ key[127-8*b -: 8];
      return res;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic new_block();
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      in_mode  = 1'($urandom_range(0, 1));
   endtask

   // one clock: score handshakes seen before the edge, then move to the next negedge
   task automatic tick();
      logic [128:0] e;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("output_when_empty", 128'(out_valid), 128'(0));
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[127:0]);
            check("out_mode", 128'(out_mode), 128'(e[128]));
            out_log.push_back(cyc);
            exp_cnt++;
         end
      end
      last_in_hs = in_valid && in_ready;
      if (last_in_hs)
         exp_q.push_back({(DEC_EN ? in_mode : 1'b0), model(in_state, in_key, in_mode)});
      @(negedge clk);
      cyc++;
   endtask

   // send one block into an empty pipe and hold it at the output
   task automatic single(input logic [127:0] st, input logic [127:0] key, input logic m);
      in_valid  = 1'b1;
      in_state  = st;
      in_key    = key;
      in_mode   = m;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
         #1 check("latency_early", 128'(out_valid), 128'(0));
         @(negedge clk);
         cyc++;
      end
      #1 check("latency", 128'(out_valid), 128'(1));
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      check("drained", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held, s_prev, exp_dec;
      logic         s_prev_mode;
      int           s_exp;

      build_tables();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_state = '0; in_key = '0; in_mode = 1'b0;
      s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_in_state = '0; s_in_key = '0; s_in_mode = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      s_rst = 1'b0;

      // reset state
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      check("rst_out_mode", 128'(out_mode), 128'(0));
      check("rst_blk_count", 128'(blk_count), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      @(negedge clk);

      // FIPS-197 final encryption round
      single(128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
      check("fips_enc", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
      check("fips_enc_mode", 128'(out_mode), 128'(0));
      out_ready = 1'b1;
      tick();
      #1 check("fips_blk_count", 128'(blk_count), 128'(1));

      // final decryption round (treated as encrypt when the path is absent)
      single(128'he9317db5cb322c723d2e895faf090794, 128'h0, 1'b1);
      exp_dec = DEC_EN ? 128'heb40f21e592e38848ba113e71bc342d2
                       : model(128'he9317db5cb322c723d2e895faf090794, 128'h0, 1'b0);
      check("fips_dec", out_data, exp_dec);
      check("fips_dec_mode", 128'(out_mode), 128'(DEC_EN));
      out_ready = 1'b1;
      tick();

      // streaming: 8 back-to-back blocks, one result per cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      out_log.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         new_block();
         in_valid = 1'b1;
         #1 check("stream_in_ready", 128'(in_ready), 128'(1));
         tick();
      end
      drain();
      check("stream_outputs", 128'(out_log.size()), 128'(8));
      if (out_log.size() == 8)
         check("stream_no_bubble", 128'(out_log[7] - out_log[0]), 128'(7));
      #1 check("stream_blk_count", 128'(blk_count), 128'(8));

      // backpressure: out_ready low for 5 cycles with a full pipe
      held = '0;
      last_in_hs = 1'b1;
      for (int i = 0; i < 20; i++) begin
         out_ready = !(i >= 8 && i < 13);
         if (last_in_hs) new_block();
         in_valid = 1'b1;
         #1;
         if (i >= 8 && i < 13) begin
            if (i == 8) held = out_data;
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_out_stable", out_data, held);
         end
         tick();
      end
      drain();
      #1 check("bp_blk_count", 128'(blk_count), 128'(exp_cnt));

      // random valid/ready mix
      last_in_hs = 1'b1;
      for (int i = 0; i < 80; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (last_in_hs || !in_valid) begin
            new_block();
            in_valid = 1'($urandom_range(0, 1));
         end
         tick();
      end
      drain();
      #1 check("rand_blk_count", 128'(blk_count), 128'(exp_cnt));

      // reset with two blocks in flight
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         new_block();
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #1 check("flight_out_valid", 128'(out_valid), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      #1;
      check("flush_out_valid", 128'(out_valid), 128'(0));
      check("flush_blk_count", 128'(blk_count), 128'(0));
      out_ready = 1'b1;
      repeat (5) tick();
      #1 check("flush_no_output", 128'(blk_count), 128'(0));

      // depth-1 instance: one-cycle latency and counter saturation at 15
      s_exp = 0;
      s_prev = '0;
      s_prev_mode = 1'b0;
      s_out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i <= 20; i++) begin
         s_in_valid = (i < 20);
         s_in_state = {$urandom, $urandom, $urandom, $urandom};
         s_in_key   = {$urandom, $urandom, $urandom, $urandom};
         s_in_mode  = 1'($urandom_range(0, 1));
         #1;
         check("sat_blk_count", 128'(s_blk_count), 128'(s_exp));
         check("sat_out_valid", 128'(s_out_valid), 128'(i > 0));
         check("sat_in_ready", 128'(s_in_ready), 128'(1));
         if (i > 0) begin
            check("sat_out_data", s_out_data, s_prev);
            check("sat_out_mode", 128'(s_out_mode), 128'(s_prev_mode));
         end
         if (s_out_valid && s_out_ready && s_exp < 15) s_exp++;
         s_prev      = model(s_in_state, s_in_key, s_in_mode);
         s_prev_mode = DEC_EN ? s_in_mode : 1'b0;
         @(negedge clk);
      end
      #1 check("sat_final", 128'(s_blk_count), 128'(15));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_final_round_pipe.md
Name: aes_final_round_pipe

Overview:
- Pipelined, parametrised AES last-round unit that replaces the purely combinational final round.
- Encrypt mode: SubBytes, ShiftRows, AddRoundKey. Decrypt mode: InvShiftRows, InvSubBytes, AddRoundKey, i.e. the last round of the inverse cipher.
- Valid/ready handshake on both sides; per-block round key and mode; saturating completed-block counter.
- Sits between the round-iteration datapath and the ciphertext/plaintext output interface.

Parameters:
- PIPE_DEPTH, 2, register stages: 1 = S-box/shift and key XOR in one stage; 2 = S-box/shift stage, then key-XOR stage.
- CNT_W, 32, width of the completed-block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_state  in  128  state, column-major; byte 0 = [127:120] = row0/col0, byte 1 = row1/col0, and so on.
- in_key  in  128  round key, same byte order.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  128  result, same byte order.
- out_mode  out  1  mode of the block in out_data.
- blk_count  out  CNT_W  saturating count of blocks accepted at the output.

Behaviour:
- Reset values: all stage valids 0; out_valid 0; out_data 0; out_mode 0; blk_count 0. in_ready = 1 in the cycle after reset.
- Reset mid-operation: in-flight blocks are discarded, never emitted.
- Per-stage register: valid bit, 128-bit data, mode bit. The key travels with the block through any earlier stage and is consumed in the last stage.
- Stage advance: stage k loads when stage k is empty OR stage k's content moves on this cycle.
  - Last stage moves when out_valid && out_ready.
  - in_ready = load-enable of stage 1, combinational from out_ready. This gives full throughput of one block per cycle with no bubbles.
- Latency: exactly PIPE_DEPTH cycles from input handshake to out_valid when unstalled.
- Backpressure: while out_ready = 0 and the pipe is full, in_ready = 0 and all stage contents hold unchanged.
- Simultaneous input and output handshake with a full pipe: both are accepted in the same cycle; no block is lost or duplicated.
- Holding stages keep their data stable, so out_data and out_mode stay stable while out_valid && !out_ready.
- Encrypt: byte (r,c) of the shifted state = S(in(r,(c+r) mod 4)).
- Decrypt: byte (r,c) = S⁻¹(in(r,(c−r) mod 4)).
- Both modes: result XOR in_key.
- S-boxes are combinational ROM functions, 16 instances per direction.
- blk_count increments on each out_valid && out_ready and saturates at all-ones (no wrap).
- An illegal PIPE_DEPTH (not 1 or 2) is a fatal elaboration error.

Optional Feature:
- Macro: AES_FINAL_ROUND_DEC_EN.
- Defined: decrypt path present, in_mode honoured.
- Undefined: inverse S-boxes and inverse shift are not instantiated; in_mode is ignored and treated as 0; out_mode is constant 0. The port list is unchanged.

Decomposition:
- Shared package aes_pkg:
  - typedef state_t (16 x 8-bit array, [row][col]).
  - localparam BLK_W = 128.
  - functions sbox(), inv_sbox(), pack_state(), unpack_state().
- One sub-module: aes_final_round_pipe_stage. It is a generic valid/ready register slice (data + mode + valid) instantiated PIPE_DEPTH times with the combinational transforms between stages.

Test Plan:
- FIPS-197 App. B, encrypt: in_state eb40f21e592e38848ba113e71bc342d2, in_key d014f9a8c9ee2589e13f0cc8b6630ca6, mode 0 -> out_data 3925841d02dc09fbdc118597196a0b32 after PIPE_DEPTH cycles; blk_count = 1.
- Decrypt (macro on): in_state e9317db5cb322c723d2e895faf090794, key 0, mode 1 -> out_data eb40f21e592e38848ba113e71bc342d2, out_mode 1.
- Streaming: 8 back-to-back blocks with out_ready tied to 1 -> in_ready stays 1 and one result per cycle, in order; blk_count = 8.
- Backpressure: out_ready low for 5 cycles mid-stream -> in_ready falls once the pipe is full; out_data stable; no loss or duplication after release.
- Reset mid-stream: rst asserted with 2 blocks in flight -> out_valid = 0 the next cycle and blk_count = 0; the flushed blocks are never output.
- Saturation: CNT_W = 4, 20 blocks -> blk_count stops at 15.
